// File: rtl/seg_scan_decoder.sv
// Read-back decoder for a 4-digit multiplexed 7-segment bus.
// Rebuilds nibbles, decimal points and blank/error flags per scan frame.
module seg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg,
  input  logic [3:0]  way,
  output logic [15:0] digits,
  output logic [3:0]  dps,
  output logic [3:0]  blank,
  output logic [3:0]  glyph_err,
  output logic        frame_valid,
  output logic        scan_timeout
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CMAX = CW'(SETTLE - 1);
  localparam logic [15:0] TMAX = 16'(TIMEOUT);

  typedef enum logic [1:0] {WAIT3, GOT3, GOT2, GOT1} state_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic       blank;
    logic       err;
  } glyph_t;

  function automatic glyph_t decode(input logic [7:0] s);
    glyph_t g;
    g = '0;
    g.dp = s[0];
    case (s[7:1])
      7'b1111110: g.nib = 4'h0;
      7'b0110000: g.nib = 4'h1;
      7'b1101101: g.nib = 4'h2;
      7'b1111001: g.nib = 4'h3;
      7'b0110011: g.nib = 4'h4;
      7'b1011011: g.nib = 4'h5;
      7'b1011111: g.nib = 4'h6;
      7'b1110000: g.nib = 4'h7;
      7'b1111111: g.nib = 4'h8;
      7'b1111011: g.nib = 4'h9;
      7'b1110011: g.nib = 4'h9;
      7'b1110111: g.nib = 4'hA;
      7'b0011111: g.nib = 4'hB;
      7'b1001110: g.nib = 4'hC;
      7'b0111101: g.nib = 4'hD;
      7'b1001111: g.nib = 4'hE;
      7'b1000111: g.nib = 4'hF;
      7'b0000000: g.blank = 1'b1;
      default:    g.err = 1'b1;
    endcase
    return g;
  endfunction

  logic [7:0]    seg_m, seg_s;
  logic [3:0]    way_m, way_s;
  logic [11:0]   s_prev;
  logic [CW-1:0] cnt, cnt_nx;
  logic [15:0]   tcnt;
  state_t        state, state_nx;
  glyph_t        sh3, sh2, sh1, cur;
  logic          onecold, same, capture, store, publish;
  logic [1:0]    idx;

  always_comb begin
    onecold = (way_s == 4'b0111) || (way_s == 4'b1011) ||
              (way_s == 4'b1101) || (way_s == 4'b1110);
    same = ({way_s, seg_s} == s_prev);
    cnt_nx = '0;
    if (same && onecold)
      cnt_nx = (cnt == CMAX) ? cnt : cnt + 1'b1;
    // fire once per stable sample: on reaching CMAX, not while parked there
    capture = onecold && (cnt_nx == CMAX) && (!same || cnt != CMAX);
    idx = 2'd0;
    case (1'b1)
      !way_s[3]: idx = 2'd3;
      !way_s[2]: idx = 2'd2;
      !way_s[1]: idx = 2'd1;
      default:   idx = 2'd0;
    endcase
    cur = decode(seg_s);
  end

  always_comb begin
    state_nx = state;
    store = 1'b0;
    publish = 1'b0;
    if (capture) begin
      state_nx = WAIT3;
      if (idx == 2'd3) begin
        state_nx = GOT3;
        store = 1'b1;
      end else if (state == GOT3 && idx == 2'd2) begin
        state_nx = GOT2;
        store = 1'b1;
      end else if (state == GOT2 && idx == 2'd1) begin
        state_nx = GOT1;
        store = 1'b1;
      end else if (state == GOT1 && idx == 2'd0) begin
        publish = 1'b1;
      end
    end else if (tcnt == TMAX) begin
      state_nx = WAIT3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m  <= '0;
      seg_s  <= '0;
      way_m  <= '0;
      way_s  <= '0;
      s_prev <= '0;
      cnt    <= '0;
      tcnt   <= '0;
      state  <= WAIT3;
    end else begin
      seg_m  <= seg;
      seg_s  <= seg_m;
      way_m  <= way;
      way_s  <= way_m;
      s_prev <= {way_s, seg_s};
      cnt    <= cnt_nx;
      state  <= state_nx;
      if (capture)
        tcnt <= '0;
      else if (tcnt != TMAX)
        tcnt <= tcnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh3         <= '0;
      sh2         <= '0;
      sh1         <= '0;
      digits      <= '0;
      dps         <= '0;
      blank       <= '0;
      glyph_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= publish;
      if (store) begin
        case (idx)
          2'd3:    sh3 <= cur;
          2'd2:    sh2 <= cur;
          default: sh1 <= cur;
        endcase
      end
      if (publish) begin
        digits    <= {sh3.nib, sh2.nib, sh1.nib, cur.nib};
        dps       <= {sh3.dp, sh2.dp, sh1.dp, cur.dp};
        blank     <= {sh3.blank, sh2.blank, sh1.blank, cur.blank};
        glyph_err <= {sh3.err, sh2.err, sh1.err, cur.err};
      end
    end
  end

  assign scan_timeout = (tcnt == TMAX);

endmodule
